// File: rtl/bch_dec_pkg.sv
// bch_dec_pkg: shared state encoding and default timing constants for the BCH decoder controller.
package bch_dec_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, EUCLID, SEL, SEARCH, REPORT} state_e;
  localparam int T_DEF        = 8;
  localparam int SYN_LEN_DEF  = 16;
  localparam int EU_LAT_DEF   = 57;
  localparam int CS_STEPS_DEF = 527;
  localparam int UIN_PHASE    = 14;
endpackage

// File: rtl/bch_dec_phase_cnt.sv
// bch_dec_phase_cnt: phase/step counter with synchronous clear (priority) and count enable.
module bch_dec_phase_cnt #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;
  assign cnt_d = clr_i ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/bch_dec_ctrl.sv
// bch_dec_ctrl: sequences syndrome load, Euclidean run and Chien search for one codeword.
// Optional stall watchdog enabled by defining BCH_DEC_CTRL_WDOG_EN.
module bch_dec_ctrl
  import bch_dec_pkg::*;
#(
  parameter int T        = T_DEF,
  parameter int SYN_LEN  = SYN_LEN_DEF,
  parameter int EU_LAT   = EU_LAT_DEF,
  parameter int CS_STEPS = CS_STEPS_DEF
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       cw_valid,
  output logic       cw_ready,
  output logic       synd_rd,
  output logic       eu_start,
  output logic       eu_stop,
  output logic       eu_rin_one,
  output logic       eu_uin_one,
  output logic       ch_sel,
  output logic       ch_adv,
  input  logic       ch_stall,
  input  logic       err_found,
  output logic       busy,
  output logic       dec_done,
  output logic [3:0] dec_nerr,
  output logic       dec_fail
);
  localparam int CMAX = EU_LAT > CS_STEPS ? EU_LAT : CS_STEPS;
  localparam int CW   = $clog2(CMAX + 1);
  state_e        state_q, state_d;
  logic [3:0]    nerr_q, nerr_d;
  logic          fail_q, fail_d;
  logic [CW-1:0] cnt;
  logic          cnt_clr, cnt_en, accept, wd_trip, wd_fail, rep_fail;
  // One counter serves as phase counter through SEL, then as Chien step counter.
  bch_dec_phase_cnt #(.W(CW)) u_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .cnt_o (cnt)
  );
  assign accept   = cw_valid & (state_q == IDLE);
  assign rep_fail = (32'(nerr_q) > T) | wd_fail;
`ifdef BCH_DEC_CTRL_WDOG_EN
  logic [3:0] wd_q, wd_d;
  logic       wdf_q, wdf_d;
  assign wd_trip = (state_q == SEARCH) & ch_stall & (wd_q == 4'hf);
  assign wd_d    = (state_q == SEARCH && ch_stall) ? wd_q + 4'd1 : 4'd0;
  assign wdf_d   = accept ? 1'b0 : (wdf_q | wd_trip);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      wd_q  <= '0;
      wdf_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      wdf_q <= wdf_d;
    end
  assign wd_fail = wdf_q;
`else
  assign wd_trip = 1'b0;
  assign wd_fail = 1'b0;
`endif
  always_comb begin
    state_d    = state_q;
    nerr_d     = nerr_q;
    fail_d     = fail_q;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    cw_ready   = 1'b0;
    synd_rd    = 1'b0;
    eu_start   = 1'b0;
    eu_stop    = 1'b0;
    eu_rin_one = 1'b0;
    eu_uin_one = 1'b0;
    ch_sel     = 1'b0;
    ch_adv     = 1'b0;
    dec_done   = 1'b0;
    dec_fail   = fail_q;
    case (state_q)
      IDLE: begin
        cw_ready   = 1'b1;
        eu_rin_one = 1'b1;
        eu_stop    = 1'b1;
        if (cw_valid) begin
          state_d = LOAD;
          cnt_clr = 1'b1;
          nerr_d  = '0;
          fail_d  = 1'b0;
        end
      end
      LOAD: begin
        synd_rd    = 1'b1;
        eu_start   = 1'b1;
        eu_stop    = cnt == '0;
        eu_uin_one = cnt == CW'(UIN_PHASE);
        cnt_en     = 1'b1;
        if (cnt == CW'(SYN_LEN - 1)) state_d = EUCLID;
      end
      EUCLID: begin
        eu_start = 1'b1;
        cnt_en   = 1'b1;
        if (cnt == CW'(EU_LAT - 1)) state_d = SEL;
      end
      SEL: begin
        ch_sel  = 1'b1;
        ch_adv  = 1'b1;
        cnt_clr = 1'b1;
        state_d = SEARCH;
      end
      SEARCH: begin
        ch_adv = ~ch_stall;
        cnt_en = ~ch_stall;
        if (wd_trip || (!ch_stall && cnt == CW'(CS_STEPS - 1))) state_d = REPORT;
      end
      REPORT: begin
        dec_done = 1'b1;
        dec_fail = rep_fail;
        fail_d   = rep_fail;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if ((state_q == SEARCH || state_q == REPORT) && err_found && nerr_q != 4'hf)
      nerr_d = nerr_q + 4'd1;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state_q <= IDLE;
      nerr_q  <= '0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      nerr_q  <= nerr_d;
      fail_q  <= fail_d;
    end
  assign busy     = state_q != IDLE;
  assign dec_nerr = nerr_q;
endmodule

// File: tb/tb_bch_dec_ctrl.sv
// tb_bch_dec_ctrl: directed bench for bch_dec_ctrl; cycle 0 is the accepting IDLE cycle.
module tb_bch_dec_ctrl;
  logic       clk = 1'b0, rstn = 1'b0, cw_valid = 1'b0, ch_stall = 1'b0, err_found = 1'b0;
  logic       cw_ready, synd_rd, eu_start, eu_stop, eu_rin_one, eu_uin_one;
  logic       ch_sel, ch_adv, busy, dec_done, dec_fail;
  logic [3:0] dec_nerr;
  int checks = 0, errors = 0;
  int done_at, first_rd, last_rd, rd_cnt, uin_at, uin_cnt, sel_at, start_cnt, adv_cnt, adv_bad;
  int nerr_k1, nerr_done, fail_done, stop_k1, stop_k2, rin_k1, busy_k300, ready_k300;
  int pre_nerr, pre_fail, pre_ready;
  bit done_seen;

  bch_dec_ctrl dut (
    .clk(clk), .rstn(rstn), .cw_valid(cw_valid), .cw_ready(cw_ready), .synd_rd(synd_rd),
    .eu_start(eu_start), .eu_stop(eu_stop), .eu_rin_one(eu_rin_one), .eu_uin_one(eu_uin_one),
    .ch_sel(ch_sel), .ch_adv(ch_adv), .ch_stall(ch_stall), .err_found(err_found),
    .busy(busy), .dec_done(dec_done), .dec_nerr(dec_nerr), .dec_fail(dec_fail)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk(tag, {cw_ready, eu_rin_one, eu_stop, eu_start, eu_uin_one, synd_rd, ch_sel, ch_adv,
              busy, dec_done, dec_fail}, 11'b111_0000_0000);
    chk({tag, "_nerr"}, dec_nerr, 0);
  endtask

  // Accept a codeword on the cycle after the previous one, then record what happens per cycle.
  task automatic run_cw(input int errs, input int bursts, input int blen);
    @(negedge clk);
    pre_nerr = dec_nerr; pre_fail = dec_fail; pre_ready = cw_ready;
    cw_valid = 1'b1;
    done_at = -1; first_rd = -1; last_rd = -1; rd_cnt = 0; uin_at = -1; uin_cnt = 0;
    sel_at = -1; start_cnt = 0; adv_cnt = 0; adv_bad = 0;
    for (int k = 1; k <= 1200; k++) begin
      @(negedge clk);
      cw_valid = (k == 300);
      if (k == 1) begin nerr_k1 = dec_nerr; stop_k1 = eu_stop; rin_k1 = eu_rin_one; end
      if (k == 2) stop_k2 = eu_stop;
      if (k == 300) begin busy_k300 = busy; ready_k300 = cw_ready; end
      if (synd_rd) begin if (first_rd < 0) first_rd = k; last_rd = k; rd_cnt++; end
      if (eu_uin_one) begin uin_at = k; uin_cnt++; end
      if (ch_sel) sel_at = k;
      if (eu_start) start_cnt++;
      if (dec_done) begin
        done_at = k; nerr_done = dec_nerr; fail_done = dec_fail;
        break;
      end
      err_found = (k >= 100 && k < 100 + 2 * errs && k % 2 == 0);
      ch_stall = 1'b0;
      for (int b = 0; b < bursts; b++)
        if (k >= 200 + b * 20 && k < 200 + b * 20 + blen) ch_stall = 1'b1;
      #1;
      if (ch_adv) adv_cnt++;
      if (ch_stall && ch_adv) adv_bad++;
    end
    cw_valid = 1'b0; err_found = 1'b0; ch_stall = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_outs("reset");
    rstn = 1'b1;
    run_cw(3, 0, 0);
    chk("rd_first", first_rd, 1);
    chk("rd_last", last_rd, 16);
    chk("rd_cnt", rd_cnt, 16);
    chk("uin_at", uin_at, 15);
    chk("uin_cnt", uin_cnt, 1);
    chk("stop_c0", stop_k1, 1);
    chk("stop_c1", stop_k2, 0);
    chk("rin_load", rin_k1, 0);
    chk("start_cnt", start_cnt, 57);
    chk("sel_at", sel_at, 58);
    chk("adv_cnt", adv_cnt, 528);
    chk("busy_mid", busy_k300, 1);
    chk("ready_mid", ready_k300, 0);
    chk("done_3", done_at, 586);
    chk("nerr_3", nerr_done, 3);
    chk("fail_3", fail_done, 0);
    run_cw(9, 0, 0);
    chk("hold_nerr", pre_nerr, 3);
    chk("hold_fail", pre_fail, 0);
    chk("hold_ready", pre_ready, 1);
    chk("clr_nerr", nerr_k1, 0);
    chk("done_9", done_at, 586);
    chk("nerr_9", nerr_done, 9);
    chk("fail_9", fail_done, 1);
    run_cw(20, 0, 0);
    chk("hold_nerr9", pre_nerr, 9);
    chk("hold_fail9", pre_fail, 1);
    chk("done_20", done_at, 586);
    chk("nerr_sat", nerr_done, 15);
    chk("fail_20", fail_done, 1);
    run_cw(0, 3, 5);
    chk("done_stall", done_at, 601);
    chk("adv_in_stall", adv_bad, 0);
    chk("adv_cnt_stall", adv_cnt, 528);
    chk("nerr_0", nerr_done, 0);
    chk("fail_0", fail_done, 0);
    @(negedge clk); cw_valid = 1'b1;
    @(negedge clk); cw_valid = 1'b0;
    repeat (100) @(negedge clk);
    err_found = 1'b1;
    repeat (3) @(negedge clk);
    err_found = 1'b0;
    repeat (200) @(negedge clk);
    chk("srch_busy", busy, 1);
    chk("srch_nerr", dec_nerr, 3);
    rstn = 1'b0;
    #1;
    chk_reset_outs("async_rst");
    @(negedge clk); rstn = 1'b1;
    done_seen = 1'b0;
    repeat (700) begin @(negedge clk); if (dec_done) done_seen = 1'b1; end
    chk("no_done_rst", done_seen, 0);
    run_cw(1, 0, 0);
    chk("done_after_rst", done_at, 586);
    chk("nerr_after_rst", nerr_done, 1);
`ifdef BCH_DEC_CTRL_WDOG_EN
    run_cw(0, 1, 40);
    chk("wdog_done", done_at, 216);
    chk("wdog_fail", fail_done, 1);
`else
    run_cw(0, 1, 200);
    chk("long_stall_done", done_at, 786);
    chk("long_stall_fail", fail_done, 0);
`endif
    chk("long_stall_adv", adv_bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bch_dec_ctrl.md
BCH_DEC_CTRL -- requirements
Module: bch_dec_ctrl

Interface
REQ-001 Parameter T, default 8: correction capability; maximum correctable error count.
REQ-002 Parameter SYN_LEN, default 16: number of syndrome cycles streamed into the Euclidean array.
REQ-003 Parameter EU_LAT, default 57: phase count at which the locator is handed to Chien search.
REQ-004 Parameter CS_STEPS, default 527: number of 8-parallel Chien advances per codeword.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rstn  in  1  reset; one clock, reset is asynchronous and active-low.
REQ-007 cw_valid  in  1  syndromes for one codeword are available.
REQ-008 cw_ready  out  1  controller idle; a codeword is accepted when cw_valid&cw_ready.
REQ-009 synd_rd  out  1  pop one 13-bit syndrome from the syndrome buffer.
REQ-010 eu_start  out  1  Euclidean array run (0 = leading coefficient locked).
REQ-011 eu_stop  out  1  Euclidean stop_i control.
REQ-012 eu_rin_one  out  1  drive Rin=1 (else 0).
REQ-013 eu_uin_one  out  1  drive Uin=1 (else 0).
REQ-014 ch_sel  out  1  Chien load-select pulse (loads the locator coefficients).
REQ-015 ch_adv  out  1  Chien advance enable.
REQ-016 ch_stall  in  1  error-address drain pending; Chien must not advance.
REQ-017 err_found  in  1  one error address recorded this cycle.
REQ-018 busy  out  1  any state other than IDLE.
REQ-019 dec_done  out  1  one-cycle completion pulse.
REQ-020 dec_nerr  out  4  errors located, saturating at 15.
REQ-021 dec_fail  out  1  uncorrectable (dec_nerr>T) or aborted.

Function
REQ-022 The FSM SHALL have states IDLE, LOAD, EUCLID, SEL, SEARCH and REPORT; a phase counter c SHALL clear on acceptance and increment once per cycle in LOAD, EUCLID and SEL.
REQ-023 In IDLE: cw_ready=1, eu_rin_one=1, eu_start=0, eu_stop=1; acceptance SHALL move to LOAD on the next edge.
REQ-024 In LOAD (c=0..SYN_LEN-1): synd_rd=1, eu_start=1, eu_rin_one=0; eu_stop=1 only at c=0; eu_uin_one=1 only at c=14; after c=SYN_LEN-1 go to EUCLID.
REQ-025 In EUCLID: eu_start=1, eu_stop=0; when c=EU_LAT-1 go to SEL.
REQ-026 SEL SHALL last one cycle with ch_sel=1 and ch_adv=1; then go to SEARCH with the step counter cleared.
REQ-027 In SEARCH: ch_adv = ~ch_stall; the step counter SHALL increment only when ch_adv=1; on reaching CS_STEPS, go to REPORT only once ch_stall=0.
REQ-028 err_found SHALL be counted only in SEARCH and REPORT entry cycle, saturating at 15.
REQ-029 REPORT SHALL last one cycle: dec_done=1, dec_fail=(count>T); then return to IDLE. dec_nerr and dec_fail SHALL hold until the next acceptance, which clears them.
REQ-030 cw_valid outside IDLE SHALL be ignored; the earliest re-acceptance is the cycle after REPORT.
REQ-031 Total latency from acceptance to dec_done SHALL be SYN_LEN... EU_LAT+1+CS_STEPS+stall cycles+1 for the default parameters, i.e. 586 cycles with no stalls.

Reset
REQ-032 On rstn=0, asynchronously: state=IDLE, counters=0, cw_ready=1, eu_rin_one=1, eu_stop=1, and all other outputs=0.
REQ-033 Reset mid-operation SHALL abandon the codeword with no dec_done pulse.

Configuration
REQ-034 When BCH_DEC_CTRL_WDOG_EN is defined, 16 consecutive ch_stall cycles in SEARCH SHALL force REPORT with dec_fail=1; when it is undefined, stalls SHALL be unbounded and no watchdog logic SHALL exist.

Structure
REQ-035 The package bch_dec_pkg SHALL hold the state enum, the T/SYN_LEN/EU_LAT/CS_STEPS defaults and the Uin-inject phase constant (14).
REQ-036 There SHALL be one sub-module, bch_dec_phase_cnt (phase/step counter with clear and enable); everything else SHALL be flat.

Verification
REQ-037 Reset then cw_valid=1 at cycle 0 -> synd_rd high for cycles 1-16; eu_uin_one high only at cycle 15; ch_sel at cycle 58.
REQ-038 No stalls, err_found pulsed 3 times -> dec_done at cycle 586 with dec_nerr=3 and dec_fail=0.
REQ-039 err_found pulsed 9 times -> dec_nerr=9, dec_fail=1; pulsed 20 times -> dec_nerr=15.
REQ-040 ch_stall held for 5 cycles, 3 times -> dec_done delayed by exactly 15 cycles; ch_adv=0 throughout each stall.
REQ-041 rstn pulsed low in SEARCH -> outputs at their reset values immediately, no dec_done, and a new codeword is accepted normally.
REQ-042 With BCH_DEC_CTRL_WDOG_EN defined, ch_stall held for 16 cycles -> dec_done with dec_fail=1; without the macro, no dec_done while the stall holds.
